// File: rtl/alu_op_scheduler.sv
// Round-robin arbiter and load/execute sequencer in front of the shared ALU datapath.
// Two requesters are served one at a time; the result is returned with the owner id.
module alu_op_scheduler #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned OPW         = 6,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [2:0]       alu_in_sel,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    output logic [OPW-1:0]   alu_out_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic [1:0]       curr_state,
    output logic [1:0]       next_state
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] LOAD = 2'b01;
    localparam logic [1:0] EXEC = 2'b10;
    localparam logic [1:0] DONE = 2'b11;

    localparam int unsigned CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             last_grant_q;
    logic [WIDTH-1:0] a_q, b_q, data_q;
    logic [OPW-1:0]   op_q;
    logic             id_q;
    logic             gnt0, gnt1;

    // On a tie the requester that was not served last wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n && state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_grant_q;
                gnt1 = ~last_grant_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (gnt0 || gnt1) state_d = LOAD;
            LOAD:    state_d = EXEC;
            EXEC:    if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!reset_n) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        a_q          <= gnt1 ? req1_a : req0_a;
                        b_q          <= gnt1 ? req1_b : req0_b;
                        op_q         <= gnt1 ? req1_op : req0_op;
                        id_q         <= gnt1;
                        last_grant_q <= gnt1;
                    end
                end
                LOAD: cnt_q <= '0;
                EXEC: begin
                    if (cnt_q == CNT_LAST) begin
                        data_q <= alu_out;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Reset is forwarded to the ALU combinationally so both clear on the same edge.
    always_comb begin
        if (!reset_n) begin
            alu_in_sel = 3'b001;
        end else if (state_q == LOAD) begin
            alu_in_sel = 3'b010;
        end else begin
            alu_in_sel = 3'b100;
        end
    end

    assign req0_ready  = gnt0;
    assign req1_ready  = gnt1;
    assign alu_num1    = a_q;
    assign alu_num2    = b_q;
    assign alu_out_sel = op_q;
    assign rsp_valid   = reset_n && (state_q == DONE);
    assign rsp_id      = id_q;
    assign rsp_data    = data_q;
    assign curr_state  = state_q;
    assign next_state  = state_d;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Scoreboard bench for alu_op_scheduler: EXEC_CYCLES=1 instance for arbitration and
// handshakes, EXEC_CYCLES=3 instance for multi-cycle execute capture.
module tb_alu_op_scheduler;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
    } rsp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [5:0] req0_op, req1_op;
    logic [2:0] alu_in_sel;
    logic [7:0] alu_num1, alu_num2, alu_out;
    logic [5:0] alu_out_sel;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [7:0] rsp_data;
    logic [1:0] curr_state, next_state;

    logic       r3_valid, r3_ready, q3_valid, q3_ready, rsp_ready3, rsp_valid3, rsp_id3;
    logic [7:0] r3_a, r3_b, q3_a, q3_b;
    logic [5:0] r3_op, q3_op, alu_out_sel3;
    logic [2:0] alu_in_sel3;
    logic [7:0] alu_num1_3, alu_num2_3, alu_out3, rsp_data3;
    logic [1:0] curr_state3, next_state3;
    logic       ovr_en;
    logic [7:0] ovr_val;

    int   n_cmp = 0;
    int   n_fail = 0;
    rsp_t sb_q[$];
    rsp_t mon_exp;

    always #5 clk = ~clk;

    // Bench ALU: plain add; the second instance can have its result overridden.
    assign alu_out  = alu_num1 + alu_num2;
    assign alu_out3 = ovr_en ? ovr_val : alu_num1_3 + alu_num2_3;

    alu_op_scheduler #(.WIDTH(8), .OPW(6), .EXEC_CYCLES(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op),
        .alu_in_sel(alu_in_sel), .alu_num1(alu_num1), .alu_num2(alu_num2),
        .alu_out_sel(alu_out_sel), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .curr_state(curr_state), .next_state(next_state)
    );

    alu_op_scheduler #(.WIDTH(8), .OPW(6), .EXEC_CYCLES(3)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(r3_valid), .req0_ready(r3_ready), .req0_a(r3_a), .req0_b(r3_b),
        .req0_op(r3_op),
        .req1_valid(q3_valid), .req1_ready(q3_ready), .req1_a(q3_a), .req1_b(q3_b),
        .req1_op(q3_op),
        .alu_in_sel(alu_in_sel3), .alu_num1(alu_num1_3), .alu_num2(alu_num2_3),
        .alu_out_sel(alu_out_sel3), .alu_out(alu_out3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3),
        .rsp_data(rsp_data3),
        .curr_state(curr_state3), .next_state(next_state3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Monitor: every accepted response must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id %0d data %0h expected none",
                         rsp_id, rsp_data);
            end else begin
                mon_exp = sb_q.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(mon_exp.id));
                check("rsp_data", 32'(rsp_data), 32'(mon_exp.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   grants;
        int   last_c;
        logic exp_id;

        reset_n = 1'b0; rsp_ready = 1'b1; ovr_en = 1'b0; ovr_val = 8'h00;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        r3_valid = 1'b0; r3_a = '0; r3_b = '0; r3_op = '0;
        q3_valid = 1'b0; q3_a = '0; q3_b = '0; q3_op = '0; rsp_ready3 = 1'b1;

        // Reset
        cyc(); cyc(); neg();
        check("rst_in_sel", 32'(alu_in_sel), 32'h1);
        check("rst_state", 32'(curr_state), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_ready0", 32'(req0_ready), 32'h0);
        check("rst_ready1", 32'(req1_ready), 32'h0);
        check("rst_num1", 32'(alu_num1), 32'h0);
        cyc(); reset_n = 1'b1; neg();
        check("idle_in_sel", 32'(alu_in_sel), 32'h4);
        check("idle_ready0", 32'(req0_ready), 32'h0);

        // Single request from req0
        cyc();
        req0_a = 8'h57; req0_b = 8'h1A; req0_op = 6'b000001; req0_valid = 1'b1;
        sb_q.push_back('{id: 1'b0, data: 8'h71});
        neg();
        check("single_ready0", 32'(req0_ready), 32'h1);
        check("single_ready1", 32'(req1_ready), 32'h0);
        check("single_next", 32'(next_state), 32'h1);
        cyc(); req0_valid = 1'b0; neg();
        check("load_state", 32'(curr_state), 32'h1);
        check("load_in_sel", 32'(alu_in_sel), 32'h2);
        check("load_num1", 32'(alu_num1), 32'h57);
        check("load_num2", 32'(alu_num2), 32'h1A);
        check("load_out_sel", 32'(alu_out_sel), 32'h1);
        check("load_ready0", 32'(req0_ready), 32'h0);
        cyc(); neg();
        check("exec_state", 32'(curr_state), 32'h2);
        check("exec_in_sel", 32'(alu_in_sel), 32'h4);
        cyc(); neg();
        check("done_state", 32'(curr_state), 32'h3);
        check("done_rsp_valid", 32'(rsp_valid), 32'h1);
        cyc(); neg();
        check("after_done_state", 32'(curr_state), 32'h0);
        check("after_done_valid", 32'(rsp_valid), 32'h0);

        // Tie and fairness after a fresh reset
        cyc(); reset_n = 1'b0; cyc(); reset_n = 1'b1;
        req0_a = 8'h10; req0_b = 8'h20; req0_op = 6'd2; req0_valid = 1'b1;
        req1_a = 8'hF0; req1_b = 8'h20; req1_op = 6'd3; req1_valid = 1'b1;
        grants = 0; last_c = 0; exp_id = 1'b0;
        for (int c = 0; c < 40 && grants < 4; c++) begin
            neg();
            if (req0_ready || req1_ready) begin
                check("grant_id", 32'(req1_ready), 32'(exp_id));
                check("grant_onehot", 32'(req0_ready & req1_ready), 32'h0);
                if (grants > 0) check("grant_spacing", 32'(c - last_c), 32'd4);
                sb_q.push_back('{id: exp_id, data: exp_id ? 8'h10 : 8'h30});
                last_c = c;
                exp_id = ~exp_id;
                grants++;
            end
            cyc();
        end
        check("grant_count", 32'(grants), 32'd4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) cyc();
        neg();
        check("fair_drain_state", 32'(curr_state), 32'h0);
        check("fair_sb_empty", 32'(sb_q.size()), 32'h0);

        // Backpressure in DONE
        cyc();
        rsp_ready = 1'b0;
        req0_a = 8'h33; req0_b = 8'h44; req0_op = 6'd4; req0_valid = 1'b1;
        sb_q.push_back('{id: 1'b0, data: 8'h77});
        neg();
        check("bp_ready0", 32'(req0_ready), 32'h1);
        cyc(); req0_valid = 1'b0; req1_valid = 1'b1;
        cyc(); cyc();
        for (int i = 0; i < 5; i++) begin
            neg();
            check("bp_state", 32'(curr_state), 32'h3);
            check("bp_valid", 32'(rsp_valid), 32'h1);
            check("bp_data", 32'(rsp_data), 32'h77);
            check("bp_id", 32'(rsp_id), 32'h0);
            check("bp_ready1", 32'(req1_ready), 32'h0);
            cyc();
        end
        rsp_ready = 1'b1; req1_valid = 1'b0;
        neg();
        check("bp_release_state", 32'(curr_state), 32'h3);
        cyc(); neg();
        check("bp_idle_state", 32'(curr_state), 32'h0);
        check("bp_idle_valid", 32'(rsp_valid), 32'h0);
        check("bp_dropped_ready1", 32'(req1_ready), 32'h0);
        check("bp_sb_empty", 32'(sb_q.size()), 32'h0);

        // Reset while in EXEC: transaction is aborted, pointer returns to req0
        cyc();
        req0_a = 8'h01; req0_b = 8'h02; req0_op = 6'd1; req0_valid = 1'b1;
        neg();
        check("abort_ready0", 32'(req0_ready), 32'h1);
        cyc(); req0_valid = 1'b0;
        cyc(); reset_n = 1'b0;
        neg();
        check("abort_exec_state", 32'(curr_state), 32'h2);
        check("abort_in_sel", 32'(alu_in_sel), 32'h1);
        cyc(); reset_n = 1'b1;
        neg();
        check("abort_state", 32'(curr_state), 32'h0);
        check("abort_valid", 32'(rsp_valid), 32'h0);
        check("abort_num1", 32'(alu_num1), 32'h0);
        cyc();
        req0_a = 8'h22; req0_b = 8'h11; req0_op = 6'd1; req0_valid = 1'b1;
        req1_a = 8'hF0; req1_b = 8'h20; req1_valid = 1'b1;
        sb_q.push_back('{id: 1'b0, data: 8'h33});
        neg();
        check("post_abort_ready0", 32'(req0_ready), 32'h1);
        check("post_abort_ready1", 32'(req1_ready), 32'h0);
        cyc(); req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) cyc();
        neg();
        check("post_abort_state", 32'(curr_state), 32'h0);
        check("post_abort_sb_empty", 32'(sb_q.size()), 32'h0);

        // EXEC_CYCLES=3 instance: capture uses the value of the last EXEC cycle
        cyc();
        r3_a = 8'h05; r3_b = 8'h06; r3_op = 6'd7; r3_valid = 1'b1;
        neg();
        check("e3_ready", 32'(r3_ready), 32'h1);
        check("e3_idle", 32'(curr_state3), 32'h0);
        cyc(); r3_valid = 1'b0; neg();
        check("e3_load", 32'(curr_state3), 32'h1);
        cyc(); neg();
        check("e3_exec1", 32'(curr_state3), 32'h2);
        check("e3_exec1_next", 32'(next_state3), 32'h2);
        cyc(); neg();
        check("e3_exec2", 32'(curr_state3), 32'h2);
        cyc(); ovr_en = 1'b1; ovr_val = 8'hA5; neg();
        check("e3_exec3", 32'(curr_state3), 32'h2);
        check("e3_exec3_next", 32'(next_state3), 32'h3);
        cyc(); neg();
        check("e3_done", 32'(curr_state3), 32'h3);
        check("e3_valid", 32'(rsp_valid3), 32'h1);
        check("e3_data", 32'(rsp_data3), 32'hA5);
        check("e3_id", 32'(rsp_id3), 32'h0);
        cyc(); neg();
        check("e3_back_idle", 32'(curr_state3), 32'h0);

        check("final_sb_empty", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
